rx_bridge: RTL and testbench

Frame receiver for the host-to-FPGA UART link on the Electrochemical Workstation board. Sits between `my_uart_rx` (single-byte strobe) and the control logic. Reassembles the 6-byte frame used on this link (header 0xAA, four payload bytes, XOR checksum of the payload) and presents the four payload bytes in parallel with a one-cycle valid pulse. Rejects frames with bad checksums and abandons frames that stall between bytes.

---
 rtl/rx_bridge.sv | 138 +++++++++++++
 tb/tb_rx_bridge.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_bridge.sv
// Frame receiver for the host-to-FPGA UART link: reassembles AA/4-payload/XOR frames
// from single-byte strobes and presents the payload in parallel with a valid pulse.
module rx_bridge #(
    parameter logic [7:0]  HEADER  = 8'hAA,
    parameter logic [19:0] TIMEOUT = 20'd150_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxen,
    input  logic [7:0] rxdb,
    output logic [7:0] Data1,
    output logic [7:0] Data2,
    output logic [7:0] Data3,
    output logic [7:0] Data4,
    output logic       DataValid,
    output logic       ChkErr,
    output logic       TimeoutErr,
    output logic       Busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        D1   = 3'd1,
        D2   = 3'd2,
        D3   = 3'd3,
        D4   = 3'd4,
        CHK  = 3'd5
    } state_t;

    state_t      state;
    logic [7:0]  shadow1;
    logic [7:0]  shadow2;
    logic [7:0]  shadow3;
    logic [7:0]  shadow4;
    logic [7:0]  csum;
    logic [19:0] cnt;

    function automatic logic [7:0] xor_acc(input logic [7:0] acc, input logic [7:0] din);
        return acc ^ din;
    endfunction

    // Frame FSM, inter-byte timeout counter and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shadow1    <= 8'h00;
            shadow2    <= 8'h00;
            shadow3    <= 8'h00;
            shadow4    <= 8'h00;
            csum       <= 8'h00;
            cnt        <= 20'd0;
            Data1      <= 8'h00;
            Data2      <= 8'h00;
            Data3      <= 8'h00;
            Data4      <= 8'h00;
            DataValid  <= 1'b0;
            ChkErr     <= 1'b0;
            TimeoutErr <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            DataValid  <= 1'b0;
            ChkErr     <= 1'b0;
            TimeoutErr <= 1'b0;
            if (rxen) begin
                // An arriving byte always beats a timeout expiring in the same cycle.
                cnt <= 20'd0;
                case (state)
                    IDLE: begin
                        if (rxdb == HEADER) begin
                            state <= D1;
                            csum  <= 8'h00;
                            Busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                            Busy  <= 1'b0;
                        end
                    end
                    D1: begin
                        shadow1 <= rxdb;
                        csum    <= xor_acc(csum, rxdb);
                        state   <= D2;
                        Busy    <= 1'b1;
                    end
                    D2: begin
                        shadow2 <= rxdb;
                        csum    <= xor_acc(csum, rxdb);
                        state   <= D3;
                        Busy    <= 1'b1;
                    end
                    D3: begin
                        shadow3 <= rxdb;
                        csum    <= xor_acc(csum, rxdb);
                        state   <= D4;
                        Busy    <= 1'b1;
                    end
                    D4: begin
                        shadow4 <= rxdb;
                        csum    <= xor_acc(csum, rxdb);
                        state   <= CHK;
                        Busy    <= 1'b1;
                    end
                    CHK: begin
                        if (rxdb == csum) begin
                            Data1     <= shadow1;
                            Data2     <= shadow2;
                            Data3     <= shadow3;
                            Data4     <= shadow4;
                            DataValid <= 1'b1;
                        end else begin
                            ChkErr <= 1'b1;
                        end
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                endcase
            end else if (state == IDLE) begin
                cnt <= 20'd0;
            end else if (cnt == TIMEOUT) begin
                state      <= IDLE;
                Busy       <= 1'b0;
                TimeoutErr <= 1'b1;
                cnt        <= 20'd0;
                csum       <= 8'h00;
                shadow1    <= 8'h00;
                shadow2    <= 8'h00;
                shadow3    <= 8'h00;
                shadow4    <= 8'h00;
            end else begin
                cnt <= cnt + 20'd1;
            end
        end
    end

endmodule

// File: tb/tb_rx_bridge.sv
// Bench for rx_bridge: a frame-level model predicts every output each cycle,
// directed frames cover good/bad checksum, header hunt, timeout, reset and back-to-back.
module tb_rx_bridge;

    localparam logic [7:0]  HDR = 8'hAA;
    localparam logic [19:0] TMO = 20'd40;
    localparam int          TO  = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxen;
    logic [7:0] rxdb;
    logic [7:0] Data1, Data2, Data3, Data4;
    logic       DataValid, ChkErr, TimeoutErr, Busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dv_cnt = 0;
    int ce_cnt = 0;
    int te_cnt = 0;
    int dv_cyc[$];

    // model state: frame in progress, bytes collected after the header, idle gap
    bit         m_in;
    logic [7:0] m_q[$];
    int         m_gap;
    logic [7:0] m_data[4];
    bit         e_dv, e_ce, e_te;

    rx_bridge #(.HEADER(HDR), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .rxen(rxen), .rxdb(rxdb),
        .Data1(Data1), .Data2(Data2), .Data3(Data3), .Data4(Data4),
        .DataValid(DataValid), .ChkErr(ChkErr), .TimeoutErr(TimeoutErr), .Busy(Busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_in = 1'b0;
        m_q.delete();
        m_gap = 0;
        for (int i = 0; i < 4; i++) m_data[i] = 8'h00;
        e_dv = 1'b0;
        e_ce = 1'b0;
        e_te = 1'b0;
    endtask

    // One sampled clock edge of the frame protocol.
    task automatic model_step(input bit en, input logic [7:0] b);
        logic [7:0] x;
        e_dv = 1'b0;
        e_ce = 1'b0;
        e_te = 1'b0;
        if (en) begin
            m_gap = 0;
            if (!m_in) begin
                if (b == HDR) begin
                    m_in = 1'b1;
                    m_q.delete();
                end
            end else if (m_q.size() < 4) begin
                m_q.push_back(b);
            end else begin
                x = m_q[0] ^ m_q[1] ^ m_q[2] ^ m_q[3];
                if (x == b) begin
                    for (int i = 0; i < 4; i++) m_data[i] = m_q[i];
                    e_dv = 1'b1;
                end else begin
                    e_ce = 1'b1;
                end
                m_in = 1'b0;
            end
        end else if (m_in) begin
            // more than TIMEOUT silent edges after the last byte abandons the frame
            m_gap++;
            if (m_gap > TO) begin
                e_te = 1'b1;
                m_in = 1'b0;
                m_gap = 0;
            end
        end
    endtask

    task automatic tick(input bit en, input logic [7:0] b);
        rxen = en;
        rxdb = b;
        @(posedge clk);
        if (rst) model_step(en, b);
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int idle);
        for (int i = 0; i < idle; i++) tick(1'b0, 8'h00);
        tick(1'b1, b);
    endtask

    task automatic send_frame(input logic [7:0] f[6], input int idle);
        for (int i = 0; i < 6; i++) send(f[i], idle);
    endtask

    task automatic check_data(input string name, input logic [31:0] exp);
        check(name, {Data1, Data2, Data3, Data4}, exp);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
        rst = 1'b1;
    endtask

    // Compare process: every output against the model on every cycle.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            check("DataValid", DataValid, e_dv);
            check("ChkErr", ChkErr, e_ce);
            check("TimeoutErr", TimeoutErr, e_te);
            check("Busy", Busy, m_in);
            check_data("Data", {m_data[0], m_data[1], m_data[2], m_data[3]});
            check("one_hot_pulse", 32'(DataValid) + 32'(ChkErr) + 32'(TimeoutErr) <= 32'd1, 32'd1);
            if (DataValid) begin
                dv_cnt++;
                dv_cyc.push_back(cyc);
            end
            if (ChkErr) ce_cnt++;
            if (TimeoutErr) te_cnt++;
        end
    end

    initial begin
        logic [7:0] good_a[6] = '{8'hAA, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        logic [7:0] bad_a[6]  = '{8'hAA, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
        logic [7:0] good_b[6] = '{8'hAA, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        int dv0, ce0, te0;
        rxen = 1'b0;
        rxdb = 8'h00;
        rst = 1'b0;
        model_reset();
        #2;
        do_reset(4);
        check_data("reset_data", 32'h0);
        check("reset_busy", Busy, 1'b0);

        // good frame, spaced
        dv0 = dv_cnt; ce0 = ce_cnt; te0 = te_cnt;
        send_frame(good_a, 10);
        tick(1'b0, 8'h00);
        check("good_dv", dv_cnt - dv0, 1);
        check("good_err", (ce_cnt - ce0) + (te_cnt - te0), 0);
        check_data("good_data", 32'h12345678);

        // bad checksum then a good frame
        dv0 = dv_cnt; ce0 = ce_cnt;
        send_frame(bad_a, 3);
        tick(1'b0, 8'h00);
        check("bad_ce", ce_cnt - ce0, 1);
        check("bad_dv", dv_cnt - dv0, 0);
        check_data("bad_hold", 32'h12345678);
        send_frame(good_b, 3);
        tick(1'b0, 8'h00);
        check_data("after_bad_data", 32'h01020304);

        // header hunt
        dv0 = dv_cnt;
        send(8'h55, 2);
        send(8'h00, 2);
        send(8'hFF, 2);
        check("hunt_busy", Busy, 1'b0);
        send_frame(good_a, 2);
        tick(1'b0, 8'h00);
        check("hunt_dv", dv_cnt - dv0, 1);
        check_data("hunt_data", 32'h12345678);

        // timeout: silence abandons the frame
        te0 = te_cnt;
        send(8'hAA, 1);
        send(8'h12, 1);
        send(8'h34, 1);
        for (int i = 0; i < TO + 5; i++) tick(1'b0, 8'h00);
        check("timeout_te", te_cnt - te0, 1);
        check("timeout_busy", Busy, 1'b0);
        send_frame(good_b, 2);
        tick(1'b0, 8'h00);
        check_data("after_timeout_data", 32'h01020304);

        // boundary: byte on the last allowed edge is accepted
        te0 = te_cnt; dv0 = dv_cnt;
        send(8'hAA, 1);
        send(8'h12, 1);
        send(8'h34, TO);
        send(8'h56, 1);
        send(8'h78, 1);
        send(8'h08, TO);
        tick(1'b0, 8'h00);
        check("edge_accept_te", te_cnt - te0, 0);
        check("edge_accept_dv", dv_cnt - dv0, 1);
        check_data("edge_accept_data", 32'h12345678);

        // boundary: one edge later the frame is dropped, remaining bytes hunted
        te0 = te_cnt; dv0 = dv_cnt;
        send(8'hAA, 1);
        send(8'h01, 1);
        for (int i = 0; i < TO + 1; i++) tick(1'b0, 8'h00);
        check("edge_late_te", te_cnt - te0, 1);
        send(8'h02, 0);
        send(8'h03, 1);
        send(8'h04, 1);
        send(8'h04, 1);
        tick(1'b0, 8'h00);
        check("edge_late_dv", dv_cnt - dv0, 0);
        check_data("edge_late_data", 32'h12345678);

        // reset mid-frame
        dv0 = dv_cnt; ce0 = ce_cnt; te0 = te_cnt;
        send(8'hAA, 1);
        send(8'h12, 1);
        send(8'h34, 1);
        do_reset(3);
        check_data("midreset_data", 32'h0);
        send(8'h56, 1);
        send(8'h78, 1);
        send(8'h08, 1);
        tick(1'b0, 8'h00);
        check("midreset_pulses", (dv_cnt - dv0) + (ce_cnt - ce0) + (te_cnt - te0), 0);
        check("midreset_busy", Busy, 1'b0);
        send_frame(good_a, 1);
        tick(1'b0, 8'h00);
        check("midreset_dv", dv_cnt - dv0, 1);

        // back-to-back frames, rxen every cycle
        dv_cyc.delete();
        send_frame(good_a, 0);
        send_frame(good_b, 0);
        tick(1'b0, 8'h00);
        check("b2b_count", dv_cyc.size(), 2);
        if (dv_cyc.size() == 2) check("b2b_spacing", dv_cyc[1] - dv_cyc[0], 6);
        check_data("b2b_data", 32'h01020304);

        tick(1'b0, 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
